// File: rtl/intr_ctrl.sv
// intr_ctrl: edge-captured, fixed-priority interrupt controller for the RAT MCU.
// Optional macro INTR_SYNC_EN adds a two-flop synchronizer on each IRQ_IN bit.
module intr_ctrl #(
    parameter int          N_SRC    = 4,
    parameter logic [9:0]  VEC_BASE = 10'h3F8,
    localparam int         IDW      = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [N_SRC-1:0] IRQ_IN,
    input  logic             I_SET,
    input  logic             I_CLR,
    input  logic             MASK_WE,
    input  logic [N_SRC-1:0] MASK_DIN,
    input  logic             INSTR_DONE,
    input  logic             INTR_ACK,
    input  logic             RETI,
    output logic             INTERRUPT,
    output logic [9:0]       INTR_VEC,
    output logic [IDW-1:0]   INTR_ID,
    output logic             I_FLAG,
    output logic [N_SRC-1:0] IRQ_PEND,
    output logic             IN_SERVICE
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [N_SRC-1:0]   cur;
    logic [N_SRC-1:0]   prev;
    logic [N_SRC-1:0]   rise;
    logic [N_SRC-1:0]   mask;
    logic [N_SRC-1:0]   eligible;
    logic [N_SRC-1:0]   clr;
    logic [IDW-1:0]     sel_id;
    logic               any;
    logic               take;
    logic               ack;

`ifdef INTR_SYNC_EN
    logic [N_SRC-1:0]   sync1;
    logic [N_SRC-1:0]   sync2;

    // two-flop synchronizer for asynchronous board inputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= IRQ_IN;
            sync2 <= sync1;
        end
    end

    assign cur = sync2;
`else
    assign cur = IRQ_IN;
`endif

    assign rise     = cur & ~prev;
    assign eligible = IRQ_PEND & mask;
    assign any      = |eligible;
    assign ack      = (state == REQ) & INTR_ACK;
    assign take     = (state == IDLE) & I_FLAG & any & INSTR_DONE;
    assign INTR_VEC = VEC_BASE + {{(10-IDW){1'b0}}, INTR_ID};

    // fixed priority: lowest eligible index wins
    always_comb begin
        sel_id = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (eligible[k]) sel_id = IDW'(k);
        end
    end

    // one-hot clear of the pending bit being acknowledged
    always_comb begin
        clr = '0;
        for (int k = 0; k < N_SRC; k++) begin
            clr[k] = ack & (INTR_ID == IDW'(k));
        end
    end

    // prev sample, pending bits (new edge beats ack clear) and mask
    always_ff @(posedge CLK) begin
        if (RESET) begin
            prev     <= '0;
            IRQ_PEND <= '0;
            mask     <= '1;
        end else begin
            prev     <= cur;
            IRQ_PEND <= (IRQ_PEND & ~clr) | rise;
            if (MASK_WE) mask <= MASK_DIN;
        end
    end

    // global enable: clear (I_CLR or ack) beats set
    always_ff @(posedge CLK) begin
        if (RESET)             I_FLAG <= 1'b0;
        else if (I_CLR | ack)  I_FLAG <= 1'b0;
        else if (I_SET)        I_FLAG <= 1'b1;
    end

    // source index is frozen from request through service
    always_ff @(posedge CLK) begin
        if (RESET)     INTR_ID <= '0;
        else if (take) INTR_ID <= sel_id;
    end

    // state register
    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (take) state_nxt = REQ;
            REQ: begin
                if (INTR_ACK)   state_nxt = SERVICE;
                else if (I_CLR) state_nxt = IDLE;
            end
            SERVICE: if (RETI) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore outputs
    always_comb begin
        INTERRUPT  = 1'b0;
        IN_SERVICE = 1'b0;
        unique case (state)
            IDLE:    ;
            REQ:     INTERRUPT  = 1'b1;
            SERVICE: IN_SERVICE = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: directed plus random checks of intr_ctrl against a cycle model.
// Honors INTR_SYNC_EN for the expected capture latency.
module tb_intr_ctrl;

`ifdef INTR_SYNC_EN
    localparam int D = 2;
`else
    localparam int D = 0;
`endif

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [3:0] IRQ_IN = '0;
    logic       I_SET = 1'b0;
    logic       I_CLR = 1'b0;
    logic       MASK_WE = 1'b0;
    logic [3:0] MASK_DIN = '0;
    logic       INSTR_DONE = 1'b0;
    logic       INTR_ACK = 1'b0;
    logic       RETI = 1'b0;
    logic       INTERRUPT;
    logic [9:0] INTR_VEC;
    logic [1:0] INTR_ID;
    logic       I_FLAG;
    logic [3:0] IRQ_PEND;
    logic       IN_SERVICE;

    int tests = 0;
    int fails = 0;

    intr_ctrl #(.N_SRC(4), .VEC_BASE(10'h3F8)) dut (
        .CLK(CLK), .RESET(RESET), .IRQ_IN(IRQ_IN),
        .I_SET(I_SET), .I_CLR(I_CLR),
        .MASK_WE(MASK_WE), .MASK_DIN(MASK_DIN),
        .INSTR_DONE(INSTR_DONE), .INTR_ACK(INTR_ACK), .RETI(RETI),
        .INTERRUPT(INTERRUPT), .INTR_VEC(INTR_VEC), .INTR_ID(INTR_ID),
        .I_FLAG(I_FLAG), .IRQ_PEND(IRQ_PEND), .IN_SERVICE(IN_SERVICE)
    );

    always #5 CLK = ~CLK;

    // reference model: mode 0 idle, 1 requesting, 2 servicing
    int       m_mode = 0;
    int       m_id = 0;
    bit [3:0] m_pend = '0;
    bit [3:0] m_mask = '1;
    bit       m_if = 1'b0;
    bit [3:0] hist [4];

    task automatic model_step();
        bit [3:0] seen;
        bit [3:0] elig;
        bit       acked;
        if (RESET) begin
            m_mode = 0; m_id = 0; m_pend = '0; m_mask = '1; m_if = 0;
            for (int i = 0; i < 4; i++) hist[i] = '0;
            return;
        end
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = IRQ_IN;
        seen  = hist[D] & ~hist[D+1];
        elig  = m_pend & m_mask;
        acked = (m_mode == 1) && INTR_ACK;
        if (acked) m_pend[m_id] = 1'b0;
        m_pend = m_pend | seen;
        if (I_CLR || acked) m_if = 1'b0;
        else if (I_SET)     m_if = 1'b1;
        case (m_mode)
            0: if (m_if_prev_ok(elig)) begin
                   m_mode = 1;
                   for (int k = 0; k < 4; k++)
                       if (elig[k]) begin m_id = k; break; end
               end
            1: if (INTR_ACK) m_mode = 2; else if (I_CLR) m_mode = 0;
            default: if (RETI) m_mode = 0;
        endcase
        if (MASK_WE) m_mask = MASK_DIN;
    endtask

    bit m_if_old = 1'b0;
    function automatic bit m_if_prev_ok(bit [3:0] elig);
        return m_if_old && (elig != 0) && INSTR_DONE;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("INTERRUPT",  32'(INTERRUPT),  32'(m_mode == 1));
        chk("IN_SERVICE", 32'(IN_SERVICE), 32'(m_mode == 2));
        chk("I_FLAG",     32'(I_FLAG),     32'(m_if));
        chk("IRQ_PEND",   32'(IRQ_PEND),   32'(m_pend));
        chk("INTR_ID",    32'(INTR_ID),    32'(m_id));
        chk("INTR_VEC",   32'(INTR_VEC),   32'h3F8 + 32'(m_id));
    endtask

    task automatic tick();
        m_if_old = m_if;
        model_step();
        @(posedge CLK);
        #1;
        check_all();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) hist[i] = '0;
        @(negedge CLK);
        RESET = 1; tick(); RESET = 0;
        chk("rst_vec", 32'(INTR_VEC), 32'h3F8);
        chk("rst_int", 32'(INTERRUPT), 32'h0);

        // basic
        I_SET = 1; tick(); I_SET = 0;
        IRQ_IN = 4'b0100; tick(); tick(); IRQ_IN = 0;
        repeat (3) tick();
        INSTR_DONE = 1; tick(); INSTR_DONE = 0;
        chk("basic_int", 32'(INTERRUPT), 32'h1);
        chk("basic_id",  32'(INTR_ID),   32'h2);
        chk("basic_vec", 32'(INTR_VEC),  32'h3FA);
        INTR_ACK = 1; tick(); INTR_ACK = 0;
        chk("basic_if",   32'(I_FLAG),     32'h0);
        chk("basic_pend", 32'(IRQ_PEND),   32'h0);
        chk("basic_svc",  32'(IN_SERVICE), 32'h1);
        RETI = 1; tick(); RETI = 0;

        // priority / mask
        MASK_WE = 1; MASK_DIN = 4'b1110; tick(); MASK_WE = 0;
        IRQ_IN = 4'b1001; tick(); tick(); IRQ_IN = 0;
        repeat (3) tick();
        chk("prio_pend", 32'(IRQ_PEND), 32'h9);
        I_SET = 1; tick(); I_SET = 0;
        INSTR_DONE = 1; tick(); INSTR_DONE = 0;
        chk("prio_id",  32'(INTR_ID),  32'h3);
        chk("prio_vec", 32'(INTR_VEC), 32'h3FB);
        INTR_ACK = 1; tick(); INTR_ACK = 0;
        chk("prio_keep0", 32'(IRQ_PEND), 32'h1);
        RETI = 1; tick(); RETI = 0;

        // gating
        MASK_WE = 1; MASK_DIN = 4'b1111; tick(); MASK_WE = 0;
        INSTR_DONE = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("gate_hold", 32'(INTERRUPT), 32'h0);
        end
        INSTR_DONE = 0;
        I_SET = 1; tick(); I_SET = 0;
        INSTR_DONE = 1; tick(); INSTR_DONE = 0;
        chk("gate_int", 32'(INTERRUPT), 32'h1);
        INTR_ACK = 1; tick(); INTR_ACK = 0;
        RETI = 1; tick(); RETI = 0;

        // collision
        I_SET = 1; tick(); I_SET = 0;
        IRQ_IN = 4'b0010; tick(); tick(); IRQ_IN = 0;
        repeat (3) tick();
        INSTR_DONE = 1; tick(); INSTR_DONE = 0;
        chk("coll_id", 32'(INTR_ID), 32'h1);
        IRQ_IN = 4'b0010;
        repeat (D) tick();
        INTR_ACK = 1; tick(); INTR_ACK = 0; IRQ_IN = 0;
        chk("coll_pend1", 32'(IRQ_PEND[1]), 32'h1);
        chk("coll_svc",   32'(IN_SERVICE),  32'h1);
        I_SET = 1; RETI = 1; tick(); I_SET = 0; RETI = 0;
        INSTR_DONE = 1; tick(); INSTR_DONE = 0;
        chk("coll_int2", 32'(INTERRUPT), 32'h1);
        chk("coll_id2",  32'(INTR_ID),   32'h1);

        // withdrawal / simultaneous set+clear
        I_CLR = 1; tick(); I_CLR = 0;
        chk("wd_int",  32'(INTERRUPT), 32'h0);
        chk("wd_pend", 32'(IRQ_PEND),  32'h2);
        I_SET = 1; I_CLR = 1; tick(); I_SET = 0; I_CLR = 0;
        chk("setclr_if", 32'(I_FLAG), 32'h0);

        // reset mid-service, then capture latency
        I_SET = 1; tick(); I_SET = 0;
        INSTR_DONE = 1; tick(); INSTR_DONE = 0;
        INTR_ACK = 1; tick(); INTR_ACK = 0;
        chk("pre_rst_svc", 32'(IN_SERVICE), 32'h1);
        RESET = 1; tick(); RESET = 0;
        chk("rst2_svc",  32'(IN_SERVICE), 32'h0);
        chk("rst2_pend", 32'(IRQ_PEND),   32'h0);
        chk("rst2_vec",  32'(INTR_VEC),   32'h3F8);
        IRQ_IN = 4'b0100;
        for (int i = 1; i <= D + 1; i++) begin
            tick();
            chk("latency", 32'(IRQ_PEND[2]), 32'(i == D + 1));
        end
        IRQ_IN = 0;
        I_SET = 1; tick(); I_SET = 0;
        INSTR_DONE = 1; tick(); INSTR_DONE = 0;
        chk("rst_mask_id", 32'(INTR_ID), 32'h2);

        // random traffic
        RESET = 1; tick(); RESET = 0;
        for (int n = 0; n < 1500; n++) begin
            RESET      = ($urandom % 97) == 0;
            if (($urandom % 4) == 0) IRQ_IN = 4'($urandom);
            I_SET      = ($urandom % 5) == 0;
            I_CLR      = ($urandom % 11) == 0;
            MASK_WE    = ($urandom % 17) == 0;
            MASK_DIN   = 4'($urandom);
            INSTR_DONE = ($urandom % 3) == 0;
            INTR_ACK   = ($urandom % 3) == 0;
            RETI       = ($urandom % 4) == 0;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
